// File: rtl/yuu_common_pkg.sv
// Shared types for the yuu common register slave: handshake FSM states and the
// registered response payload.
package yuu_common_pkg;

  // Widest register supported; narrower instances use the low bits of rdata.
  localparam int MAX_DATA_W = 64;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  error;
  } rsp_t;

endpackage

// File: rtl/yuu_common_reg_slave.sv
// Register slave: valid/ready request port, a held response, sticky hw_set bits.
// Optional macro YUU_COMMON_REG_SLAVE_ERR_EN flags out-of-range accesses with rsp_error.
module yuu_common_reg_slave
  import yuu_common_pkg::*;
#(
  parameter int                         ADDR_W   = 8,
  parameter int                         DATA_W   = 32,
  parameter int                         NUM_REGS = 16,
  parameter logic [NUM_REGS*DATA_W-1:0] WR_MASK  = '1,
  parameter logic [NUM_REGS*DATA_W-1:0] RST_VAL  = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_error,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

  localparam int          STRB_W     = DATA_W / 8;
  localparam int          IDX_LSB    = $clog2(STRB_W);
  localparam int          IDX_W      = ADDR_W - IDX_LSB;
  localparam logic [31:0] NUM_REGS_U = NUM_REGS;

  state_e              state_q;
  state_e              state_d;
  rsp_t                rsp_q;
  rsp_t                rsp_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [IDX_W-1:0]    req_idx;
  logic [31:0]         idx_ext;
  logic                in_range;
  logic                accept;
  logic                wr_accept;
  logic [DATA_W-1:0]   strb_mask;
  logic [DATA_W-1:0]   rd_val;

  assign req_idx   = req_addr[ADDR_W-1:IDX_LSB];
  assign idx_ext   = 32'(req_idx);
  assign in_range  = (idx_ext < NUM_REGS_U);
  assign accept    = req_valid & req_ready;
  assign wr_accept = accept & req_write & in_range;

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < STRB_W; b++) begin
      strb_mask[b*8 +: 8] = {8{req_strb[b]}};
    end
  end

  // Read mux compares the full index so out-of-range reads fall through to zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx_ext == 32'(i)) begin
        rd_val = regs_q[i];
      end
    end
  end

  // hw_set is applied after the software write so a same-cycle collision ends at 1.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_accept && (idx_ext == 32'(i))) begin
        regs_d[i] = (req_wdata & strb_mask & WR_MASK[i*DATA_W +: DATA_W]) |
                    (regs_q[i] & ~(strb_mask & WR_MASK[i*DATA_W +: DATA_W]));
      end
      regs_d[i] = regs_d[i] | hw_set[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // The response is captured at accept and held untouched for the whole RESP state.
  always_comb begin
    rsp_d = rsp_q;
    if (accept) begin
      rsp_d.rdata = (req_write || !in_range) ? '0 : MAX_DATA_W'(rd_val);
`ifdef YUU_COMMON_REG_SLAVE_ERR_EN
      rsp_d.error = !in_range;
`else
      rsp_d.error = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
  assign rsp_error = rsp_q.error;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  if (IDX_LSB > 0) begin : g_addr_lsb
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[IDX_LSB-1:0];
  end

  if (DATA_W < MAX_DATA_W) begin : g_rdata_hi
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^rsp_q.rdata[MAX_DATA_W-1:DATA_W];
  end

endmodule

// File: tb/tb_yuu_common_reg_slave.sv
// Self-checking bench for yuu_common_reg_slave: directed scenarios plus random
// traffic against a bit-level register model kept in the bench.
module tb_yuu_common_reg_slave;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam int VW = NR * DW;

  // reg1 has a partial write mask, reg5 is fully read-only.
  localparam logic [VW-1:0] TB_WR_MASK = {{10{32'hFFFF_FFFF}}, 32'h0000_0000,
                                          {3{32'hFFFF_FFFF}}, 32'hFFFF_00FF, 32'hFFFF_FFFF};
  localparam logic [VW-1:0] TB_RST_VAL = {{10{32'h0}}, 32'hCAFE_0000, 32'h0,
                                          32'h1234_5678, 32'h0, 32'h0000_00A5, 32'h0};
`ifdef YUU_COMMON_REG_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [7:0]    req_addr;
  logic [31:0]   req_wdata;
  logic [3:0]    req_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [VW-1:0] hw_set;
  logic [VW-1:0] reg_q;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [NR];
  bit          m_busy;
  logic [31:0] m_rdata;
  bit          m_err;

  yuu_common_reg_slave #(
    .ADDR_W  (8),
    .DATA_W  (DW),
    .NUM_REGS(NR),
    .WR_MASK (TB_WR_MASK),
    .RST_VAL (TB_RST_VAL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_strb (req_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .hw_set   (hw_set),
    .reg_q    (reg_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit w, input logic [7:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input bit rr, input logic [VW-1:0] hs);
    req_valid = v;
    req_write = w;
    req_addr  = addr;
    req_wdata = wdata;
    req_strb  = strb;
    rsp_ready = rr;
    hw_set    = hs;
  endtask

  function automatic logic [VW-1:0] packModel();
    logic [VW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_regs[i];
    return v;
  endfunction

  task automatic resetModel();
    for (int i = 0; i < NR; i++) m_regs[i] = TB_RST_VAL[i*DW +: DW];
    m_busy  = 0;
    m_rdata = '0;
    m_err   = 0;
  endtask

  // One clock edge: advance the model with the inputs present at the edge, then compare.
  task automatic tick();
    int idx;
    bit ok;
    logic [31:0] wm;
    @(posedge clk);
    if (m_busy) begin
      if (rsp_ready) m_busy = 0;
    end else if (req_valid) begin
      idx     = int'(req_addr) / 4;
      ok      = (idx < NR);
      m_busy  = 1;
      m_err   = ERR_EN && !ok;
      m_rdata = (!req_write && ok) ? m_regs[idx] : 32'h0;
      if (req_write && ok) begin
        wm = TB_WR_MASK[idx*DW +: DW];
        for (int k = 0; k < DW; k++) begin
          if (req_strb[k/8] && wm[k]) m_regs[idx][k] = req_wdata[k];
        end
      end
    end
    for (int i = 0; i < NR; i++) m_regs[i] = m_regs[i] | hw_set[i*DW +: DW];
    #1;
    checkOutput("reg_q", reg_q, packModel());
    checkOutput("req_ready", VW'(req_ready), VW'(!m_busy));
    checkOutput("rsp_valid", VW'(rsp_valid), VW'(m_busy));
    if (m_busy) begin
      checkOutput("rsp_rdata", VW'(rsp_rdata), VW'(m_rdata));
      checkOutput("rsp_error", VW'(rsp_error), VW'(m_err));
    end
  endtask

  initial begin
    logic [VW-1:0] hs;
    rst_n = 1'b0;
    applyStimulus(0, 0, 8'h0, 32'h0, 4'h0, 1, '0);
    resetModel();
    #12;
    checkOutput("rst_rsp_valid", VW'(rsp_valid), VW'(0));
    checkOutput("rst_rsp_rdata", VW'(rsp_rdata), VW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_reg1", VW'(reg_q[63:32]), VW'(32'h0000_00A5));
    checkOutput("rst_req_ready", VW'(req_ready), VW'(1));
    checkOutput("rst_reg_q", reg_q, TB_RST_VAL);

    // Strobed write into the partially writable reg1, then read it back.
    applyStimulus(1, 1, 8'h04, 32'hDEAD_BEEF, 4'b0011, 1, '0);
    tick();
    checkOutput("wr_reg1", VW'(reg_q[63:32]), VW'(32'h0000_00EF));
    checkOutput("wr_rdata_zero", VW'(rsp_rdata), VW'(0));
    applyStimulus(0, 0, 8'h0, 32'h0, 4'h0, 1, '0);
    tick();
    applyStimulus(1, 0, 8'h04, 32'h0, 4'h0, 1, '0);
    tick();
    checkOutput("rd_reg1", VW'(rsp_rdata), VW'(32'h0000_00EF));
    applyStimulus(0, 0, 8'h0, 32'h0, 4'h0, 1, '0);
    tick();

    // Backpressure: response held for five cycles while another request waits.
    applyStimulus(1, 0, 8'h05, 32'h0, 4'h0, 0, '0);
    tick();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1, 0, 8'h08, 32'h0, 4'h0, 0, '0);
      tick();
      checkOutput("bp_rdata", VW'(rsp_rdata), VW'(32'h0000_00EF));
      checkOutput("bp_req_ready", VW'(req_ready), VW'(0));
    end
    applyStimulus(1, 0, 8'h08, 32'h0, 4'h0, 1, '0);
    tick();
    checkOutput("bp_done_valid", VW'(rsp_valid), VW'(0));
    tick();
    applyStimulus(0, 0, 8'h0, 32'h0, 4'h0, 1, '0);
    tick();

    // Collision of a zero write with hw_set on reg2 bit0.
    hs = '0;
    hs[64] = 1'b1;
    applyStimulus(1, 1, 8'h08, 32'h0, 4'hF, 1, hs);
    tick();
    checkOutput("collide_reg2", VW'(reg_q[95:64]), VW'(32'h1));
    applyStimulus(0, 0, 8'h0, 32'h0, 4'h0, 1, '0);
    tick();

    // Zero strobe, read-only register and out-of-range accesses.
    applyStimulus(1, 1, 8'h0C, 32'hFFFF_FFFF, 4'h0, 1, '0);
    tick();
    checkOutput("strb0_reg3", VW'(reg_q[127:96]), VW'(32'h1234_5678));
    tick();
    applyStimulus(1, 1, 8'h14, 32'hFFFF_FFFF, 4'hF, 1, '0);
    tick();
    checkOutput("ro_reg5", VW'(reg_q[191:160]), VW'(32'hCAFE_0000));
    tick();
    applyStimulus(1, 0, 8'h40, 32'h0, 4'h0, 0, '0);
    tick();
    checkOutput("oor_rdata", VW'(rsp_rdata), VW'(0));
    checkOutput("oor_error", VW'(rsp_error), VW'(ERR_EN));
    applyStimulus(1, 1, 8'h44, 32'hFFFF_FFFF, 4'hF, 1, '0);
    tick();
    tick();
    tick();

    // Random traffic, including unaligned and out-of-range addresses.
    for (int n = 0; n < 300; n++) begin
      hs = '0;
      if ($urandom_range(7) == 0) hs[$urandom_range(VW-1)] = 1'b1;
      applyStimulus(bit'($urandom_range(1)), bit'($urandom_range(1)),
                    8'($urandom_range(8'h4F)), $urandom, 4'($urandom_range(15)),
                    bit'($urandom_range(3) != 0), hs);
      tick();
    end

    // Reset while a response is pending.
    applyStimulus(1, 0, 8'h0C, 32'h0, 4'h0, 0, '0);
    tick();
    if (!m_busy) begin
      applyStimulus(0, 0, 8'h0, 32'h0, 4'h0, 0, '0);
      tick();
    end
    checkOutput("pre_rst_valid", VW'(rsp_valid), VW'(1));
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput("midrst_valid", VW'(rsp_valid), VW'(0));
    checkOutput("midrst_reg_q", reg_q, TB_RST_VAL);
    checkOutput("midrst_ready", VW'(req_ready), VW'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 8'h0, 32'h0, 4'h0, 1, '0);
    tick();
    for (int n = 0; n < 40; n++) begin
      applyStimulus(bit'($urandom_range(1)), bit'($urandom_range(1)),
                    8'($urandom_range(8'h4F)), $urandom, 4'($urandom_range(15)),
                    bit'($urandom_range(1)), '0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
